jamma_joy_scanner: RTL and testbench

Time-multiplexed scanner for the JAMMA joystick splitter. Drives the bank-select line, waits for the external mux to settle, samples the shared 8-bit joystick bus once per bank, and publishes per-player debounced control vectors plus debounced coins to the arcade core. Sits between the board pins (JJOY, JCOIN, JSELECT, local JOYSTICK) and the core's I_JOYSTICK_A/B, I_PLAYER and I_COIN inputs. Runs on the core pixel clock.

---
 rtl/jamma_joy_scanner.sv | 243 ++++++++++++++++++++++++
 tb/tb_jamma_joy_scanner.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jamma_joy_scanner.sv
// Two-bank JAMMA joystick scanner: bank select, settle, single-cycle sample, per-channel debounce.
// Optional macro JOY_MERGE_DB9_EN merges the local DB9 JOYSTICK input into the bank-1 sample.
module jamma_joy_scanner #(
    parameter int SETTLE_CYCLES    = 8,
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       hold,
    input  logic [7:0] JJOY,
    input  logic [1:0] JCOIN,
    input  logic [5:0] JOYSTICK,
    output logic       JSELECT,
    output logic [7:0] joystick1,
    output logic [7:0] joystick2,
    output logic [1:0] coin,
    output logic       scan_done
);

    localparam int               CNT_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       DB_TARGET   = 4'(DEBOUNCE_SAMPLES);

    typedef enum logic [1:0] {
        SEL1_SETTLE = 2'd0,
        SEL1_SAMPLE = 2'd1,
        SEL2_SETTLE = 2'd2,
        SEL2_SAMPLE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_settle_cnt;
    logic             r_jselect;
    logic             r_scan_done;
    logic [7:0]       r_joy1;
    logic [7:0]       r_joy2;
    logic [1:0]       r_coin;

    logic [7:0]       r_jjoy_s1;
    logic [7:0]       r_jjoy_s2;
    logic [1:0]       r_jcoin_s1;
    logic [1:0]       r_jcoin_s2;

    logic [7:0]       r_b1_prev;
    logic [7:0]       r_b2_prev;
    logic [1:0]       r_coin_prev;
    logic [3:0]       r_b1_cnt;
    logic [3:0]       r_b2_cnt;
    logic [3:0]       r_coin_cnt;

    logic             w_settle_done;
    logic             w_take_b1;
    logic             w_take_b2;
    logic             w_jselect_nxt;
    logic [7:0]       w_bank1_sample;
    logic [3:0]       w_b1_cnt_nxt;
    logic [3:0]       w_b2_cnt_nxt;
    logic [3:0]       w_coin_cnt_nxt;

    // Run length of identical samples, saturating at the debounce target.
    function automatic logic [3:0] db_next_cnt(input logic same, input logic [3:0] cnt);
        logic [3:0] nxt;
        if (!same) begin
            nxt = 4'd1;
        end else if (cnt >= DB_TARGET) begin
            nxt = DB_TARGET;
        end else begin
            nxt = cnt + 4'd1;
        end
        return nxt;
    endfunction

    // Two-flop synchronizers for the asynchronous pin inputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_jjoy_s1  <= 8'hFF;
            r_jjoy_s2  <= 8'hFF;
            r_jcoin_s1 <= 2'b11;
            r_jcoin_s2 <= 2'b11;
        end else begin
            r_jjoy_s1  <= JJOY;
            r_jjoy_s2  <= r_jjoy_s1;
            r_jcoin_s1 <= JCOIN;
            r_jcoin_s2 <= r_jcoin_s1;
        end
    end

`ifdef JOY_MERGE_DB9_EN
    logic [5:0] r_db9_s1;
    logic [5:0] r_db9_s2;

    // DB9 synchronizer; a low bit from either source asserts the bank-1 bit.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_db9_s1 <= 6'h3F;
            r_db9_s2 <= 6'h3F;
        end else begin
            r_db9_s1 <= JOYSTICK;
            r_db9_s2 <= r_db9_s1;
        end
    end

    assign w_bank1_sample = r_jjoy_s2 & {2'b11, r_db9_s2};
`else
    logic w_unused_joystick;
    assign w_unused_joystick = &JOYSTICK;
    assign w_bank1_sample    = r_jjoy_s2;
`endif

    assign w_settle_done  = (r_settle_cnt == SETTLE_LAST);
    assign w_b1_cnt_nxt   = db_next_cnt(w_bank1_sample == r_b1_prev, r_b1_cnt);
    assign w_b2_cnt_nxt   = db_next_cnt(r_jjoy_s2 == r_b2_prev, r_b2_cnt);
    assign w_coin_cnt_nxt = db_next_cnt(r_jcoin_s2 == r_coin_prev, r_coin_cnt);

    // FSM state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= SEL1_SETTLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; hold pins the current state.
    always_comb begin
        w_state_nxt = r_state;
        if (hold) begin
            w_state_nxt = r_state;
        end else begin
            case (r_state)
                SEL1_SETTLE: w_state_nxt = w_settle_done ? SEL1_SAMPLE : SEL1_SETTLE;
                SEL1_SAMPLE: w_state_nxt = SEL2_SETTLE;
                SEL2_SETTLE: w_state_nxt = w_settle_done ? SEL2_SAMPLE : SEL2_SETTLE;
                SEL2_SAMPLE: w_state_nxt = SEL1_SETTLE;
                default:     w_state_nxt = SEL1_SETTLE;
            endcase
        end
    end

    // FSM output decode: sample strobes and the bank select for the next state.
    always_comb begin
        w_take_b1     = 1'b0;
        w_take_b2     = 1'b0;
        w_jselect_nxt = 1'b0;
        case (r_state)
            SEL1_SAMPLE: w_take_b1 = !hold;
            SEL2_SAMPLE: w_take_b2 = !hold;
            default:     w_take_b1 = 1'b0;
        endcase
        case (w_state_nxt)
            SEL2_SETTLE: w_jselect_nxt = 1'b1;
            SEL2_SAMPLE: w_jselect_nxt = 1'b1;
            default:     w_jselect_nxt = 1'b0;
        endcase
    end

    // Settle counter restarts on every state change and freezes under hold.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_settle_cnt <= '0;
        end else if (hold) begin
            r_settle_cnt <= r_settle_cnt;
        end else if (w_state_nxt != r_state) begin
            r_settle_cnt <= '0;
        end else begin
            r_settle_cnt <= r_settle_cnt + CNT_W'(1);
        end
    end

    // Registered bank select and end-of-scan pulse.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_jselect   <= 1'b0;
            r_scan_done <= 1'b0;
        end else begin
            r_jselect   <= w_jselect_nxt;
            r_scan_done <= w_take_b2;
        end
    end

    // Bank-1 debounce.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_b1_prev <= 8'hFF;
            r_b1_cnt  <= 4'd0;
            r_joy1    <= 8'hFF;
        end else if (w_take_b1) begin
            r_b1_prev <= w_bank1_sample;
            r_b1_cnt  <= w_b1_cnt_nxt;
            if (w_b1_cnt_nxt == DB_TARGET) begin
                r_joy1 <= w_bank1_sample;
            end else begin
                r_joy1 <= r_joy1;
            end
        end else begin
            r_b1_prev <= r_b1_prev;
            r_b1_cnt  <= r_b1_cnt;
            r_joy1    <= r_joy1;
        end
    end

    // Bank-2 and coin debounce share the SEL2 sample strobe.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_b2_prev   <= 8'hFF;
            r_b2_cnt    <= 4'd0;
            r_joy2      <= 8'hFF;
            r_coin_prev <= 2'b11;
            r_coin_cnt  <= 4'd0;
            r_coin      <= 2'b11;
        end else if (w_take_b2) begin
            r_b2_prev   <= r_jjoy_s2;
            r_b2_cnt    <= w_b2_cnt_nxt;
            r_coin_prev <= r_jcoin_s2;
            r_coin_cnt  <= w_coin_cnt_nxt;
            if (w_b2_cnt_nxt == DB_TARGET) begin
                r_joy2 <= r_jjoy_s2;
            end else begin
                r_joy2 <= r_joy2;
            end
            if (w_coin_cnt_nxt == DB_TARGET) begin
                r_coin <= r_jcoin_s2;
            end else begin
                r_coin <= r_coin;
            end
        end else begin
            r_b2_prev   <= r_b2_prev;
            r_b2_cnt    <= r_b2_cnt;
            r_joy2      <= r_joy2;
            r_coin_prev <= r_coin_prev;
            r_coin_cnt  <= r_coin_cnt;
            r_coin      <= r_coin;
        end
    end

    assign JSELECT   = r_jselect;
    assign joystick1 = r_joy1;
    assign joystick2 = r_joy2;
    assign coin      = r_coin;
    assign scan_done = r_scan_done;

endmodule

// File: tb/tb_jamma_joy_scanner.sv
// Scoreboard bench for jamma_joy_scanner: a scan-phase reference model predicts every scan result,
// a monitor pops predictions on scan_done; directed scenarios are followed by randomized traffic.
`timescale 1ns/1ps
module tb_jamma_joy_scanner;

    localparam int S = 8;
    localparam int D = 4;
    localparam int P = 2 * (S + 1);

`ifdef JOY_MERGE_DB9_EN
    localparam logic [7:0] DB9_EXP = 8'hFB;
`else
    localparam logic [7:0] DB9_EXP = 8'hFF;
`endif

    logic       CLK      = 1'b0;
    logic       RESET    = 1'b1;
    logic       hold     = 1'b0;
    logic [7:0] JJOY     = 8'hFF;
    logic [1:0] JCOIN    = 2'b11;
    logic [5:0] JOYSTICK = 6'h3F;
    logic       JSELECT;
    logic [7:0] joystick1;
    logic [7:0] joystick2;
    logic [1:0] coin;
    logic       scan_done;

    jamma_joy_scanner #(.SETTLE_CYCLES(S), .DEBOUNCE_SAMPLES(D)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .hold      (hold),
        .JJOY      (JJOY),
        .JCOIN     (JCOIN),
        .JOYSTICK  (JOYSTICK),
        .JSELECT   (JSELECT),
        .joystick1 (joystick1),
        .joystick2 (joystick2),
        .coin      (coin),
        .scan_done (scan_done)
    );

    always #5 CLK = ~CLK;

    logic [7:0] p1_pins = 8'hFF;
    logic [7:0] p2_pins = 8'hFF;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         cyc;
        logic [7:0] j1;
        logic [7:0] j2;
        logic [1:0] c;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state: scan position and pin histories.
    int         cyc = 0;
    int         m_phase;
    logic [7:0] hj1, hj2;
    logic [1:0] hc1, hc2;
`ifdef JOY_MERGE_DB9_EN
    logic [5:0] hd1, hd2;
`endif
    logic [7:0] m_j1, m_j2;
    logic [1:0] m_coin;
    logic [7:0] last1, last2, smp1;
    logic [1:0] lastc;
    int         run1, run2, runc;
    exp_t       e_push, e_pop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        hj1 = 8'hFF; hj2 = 8'hFF;
        hc1 = 2'b11; hc2 = 2'b11;
`ifdef JOY_MERGE_DB9_EN
        hd1 = 6'h3F; hd2 = 6'h3F;
`endif
        m_j1 = 8'hFF; m_j2 = 8'hFF; m_coin = 2'b11;
        last1 = 8'hFF; last2 = 8'hFF; lastc = 2'b11;
        run1 = 0; run2 = 0; runc = 0;
        exp_q.delete();
    endtask

    // Reference model: scan position 0..P-1, samples at positions S and P-1, run-length debounce.
    initial begin
        model_reset();
        forever begin
            @(posedge CLK or posedge RESET);
            if (RESET) begin
                model_reset();
            end else begin
                cyc++;
                if (!hold && m_phase == S) begin
`ifdef JOY_MERGE_DB9_EN
                    smp1 = hj2 & {2'b11, hd2};
`else
                    smp1 = hj2;
`endif
                    if (smp1 == last1) run1++; else begin last1 = smp1; run1 = 1; end
                    if (run1 >= D) m_j1 = smp1;
                end
                if (!hold && m_phase == P - 1) begin
                    if (hj2 == last2) run2++; else begin last2 = hj2; run2 = 1; end
                    if (run2 >= D) m_j2 = hj2;
                    if (hc2 == lastc) runc++; else begin lastc = hc2; runc = 1; end
                    if (runc >= D) m_coin = hc2;
                    e_push.cyc = cyc;
                    e_push.j1  = m_j1;
                    e_push.j2  = m_j2;
                    e_push.c   = m_coin;
                    exp_q.push_back(e_push);
                end
                hj2 = hj1; hj1 = JJOY;
                hc2 = hc1; hc1 = JCOIN;
`ifdef JOY_MERGE_DB9_EN
                hd2 = hd1; hd1 = JOYSTICK;
`endif
                if (!hold) m_phase = (m_phase + 1) % P;
            end
        end
    end

    // External mux emulation: the bus shows the bank chosen by JSELECT.
    initial begin
        forever begin
            @(negedge CLK);
            JJOY = JSELECT ? p2_pins : p1_pins;
        end
    end

    // Monitor: per-cycle select/output checks, scoreboard pop on each scan_done.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                check("jselect", 32'(JSELECT), 32'(m_phase > S));
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e_pop = exp_q.pop_front();
                    check("scan_done", 32'(scan_done), 32'd1);
                    check("scan_joy1", 32'(joystick1), 32'(e_pop.j1));
                    check("scan_joy2", 32'(joystick2), 32'(e_pop.j2));
                    check("scan_coin", 32'(coin), 32'(e_pop.c));
                end else begin
                    check("scan_done_idle", 32'(scan_done), 32'd0);
                end
                check("joy1_cycle", 32'(joystick1), 32'(m_j1));
                check("joy2_cycle", 32'(joystick2), 32'(m_j2));
                check("coin_cycle", 32'(coin), 32'(m_coin));
            end
        end
    end

    task automatic wait_scan(output int k);
        k = 0;
        forever begin
            @(negedge CLK);
            k++;
            if (scan_done || k >= 4 * P) break;
        end
        check("scan_timeout", 32'(scan_done), 32'd1);
    endtask

    task automatic wait_phase(input int target);
        int k;
        k = 0;
        while (m_phase != target && k < 4 * P) begin
            @(negedge CLK);
            k++;
        end
        check("phase_timeout", 32'(m_phase), 32'(target));
    endtask

    initial begin
        int k;
        repeat (3) @(negedge CLK);
        check("rst_jselect", 32'(JSELECT), 32'd0);
        check("rst_joy1", 32'(joystick1), 32'hFF);
        check("rst_joy2", 32'(joystick2), 32'hFF);
        check("rst_coin", 32'(coin), 32'd3);
        check("rst_scan_done", 32'(scan_done), 32'd0);
        RESET = 1'b0;

        // Idle scanning with all inputs released.
        wait_scan(k);
        check("first_scan", 32'(k), 32'(P));
        wait_scan(k);
        check("scan_period", 32'(k), 32'(P));
        wait_scan(k);
        check("scan_period2", 32'(k), 32'(P));
        check("idle_joy1", 32'(joystick1), 32'hFF);

        // Bank-1 press only.
        p1_pins = 8'hFE;
        repeat (5) wait_scan(k);
        check("b1_press_joy1", 32'(joystick1), 32'hFE);
        check("b1_press_joy2", 32'(joystick2), 32'hFF);
        p1_pins = 8'hFF;

        // Bank-2 glitch of 3 scans; coin held for 4 scans.
        p2_pins = 8'h7F;
        JCOIN   = 2'b10;
        repeat (3) wait_scan(k);
        p2_pins = 8'hFF;
        wait_scan(k);
        check("coin_after4", 32'(coin), 32'd2);
        check("b2_short_joy2", 32'(joystick2), 32'hFF);
        repeat (2) wait_scan(k);
        check("b2_short_joy2_late", 32'(joystick2), 32'hFF);
        check("b1_release_joy1", 32'(joystick1), 32'hFF);
        JCOIN = 2'b11;

        // Local DB9 joystick.
        JOYSTICK = 6'b111011;
        repeat (5) wait_scan(k);
        check("db9_joy1", 32'(joystick1), 32'(DB9_EXP));
        JOYSTICK = 6'h3F;
        repeat (5) wait_scan(k);

        // Hold in the third cycle of SEL2 settle.
        wait_phase(S + 3);
        hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check("hold_jselect", 32'(JSELECT), 32'd1);
            check("hold_scan_done", 32'(scan_done), 32'd0);
        end
        hold = 1'b0;
        wait_scan(k);
        check("hold_resume", 32'(k), 32'd7);

        // Asynchronous reset mid SEL2 settle with joystick1 pressed.
        p1_pins = 8'hFE;
        repeat (5) wait_scan(k);
        check("pre_rst_joy1", 32'(joystick1), 32'hFE);
        wait_phase(S + 3);
        RESET = 1'b1;
        #1;
        check("async_rst_joy1", 32'(joystick1), 32'hFF);
        check("async_rst_jselect", 32'(JSELECT), 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        wait_scan(k);
        check("restart_scan", 32'(k), 32'(P));

        // Randomized pins, glitches and hold.
        for (int i = 0; i < 2500; i++) begin
            @(negedge CLK);
            hold = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 89) == 0) p1_pins = 8'($urandom);
            if ($urandom_range(0, 89) == 0) p2_pins = 8'($urandom);
            if ($urandom_range(0, 99) == 0) JCOIN = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) JOYSTICK = 6'($urandom);
        end
        hold = 1'b0;
        repeat (3) wait_scan(k);
        @(negedge CLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
